inst_fetch_unit: RTL and testbench

Front-end fetch engine and the producer for the instruction queue. Generates the PC, reads one instruction at a time from instruction memory over a request/valid handshake, and applies static branch prediction. Pushes {inst, pc, pred, pred_target} into the queue's write port. On a branch-misprediction flush it redirects the PC and discards any in-flight memory response.

---
 rtl/inst_fetch_unit.sv | 127 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch engine: PC generation, single-outstanding memory read,
// static branch prediction and push into the instruction queue.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_data_i,
    input  logic        iq_full_i,
    output logic        iq_we_o,
    output logic [31:0] iq_inst_o,
    output logic [31:0] iq_pc_o,
    output logic        iq_pred_o,
    output logic [31:0] iq_pred_target_o
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_PUSH,
        S_DROP
    } state_t;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] inst_q;
    logic [31:0] pc_q;
    logic        pred_q;
    logic [31:0] tgt_q;

    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic [31:0] pc_plus4;
    logic        pred;
    logic [31:0] pred_tgt;

    // Prediction is evaluated on the returning word while pc still holds its address
    always_comb begin
        j_imm    = {{11{mem_data_i[31]}}, mem_data_i[31], mem_data_i[19:12],
                    mem_data_i[20], mem_data_i[30:21], 1'b0};
        b_imm    = {{19{mem_data_i[31]}}, mem_data_i[31], mem_data_i[7],
                    mem_data_i[30:25], mem_data_i[11:8], 1'b0};
        pc_plus4 = pc + 32'd4;
        pred     = 1'b0;
        pred_tgt = pc_plus4;
        case (mem_data_i[6:0])
            OP_JAL: begin
                pred     = 1'b1;
                pred_tgt = pc + j_imm;
            end
            OP_BRANCH: begin
                pred = mem_data_i[31];
                if (mem_data_i[31]) begin
                    pred_tgt = pc + b_imm;
                end
            end
            default: begin
                pred     = 1'b0;
                pred_tgt = pc_plus4;
            end
        endcase
    end

    assign mem_addr_o       = pc;
    assign mem_req_o        = (state == S_FETCH) & ~iq_full_i & ~flush_i & rst;
    assign iq_we_o          = (state == S_PUSH) & ~flush_i & rst;
    assign iq_inst_o        = inst_q;
    assign iq_pc_o          = pc_q;
    assign iq_pred_o        = pred_q;
    assign iq_pred_target_o = tgt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            inst_q <= '0;
            pc_q   <= '0;
            pred_q <= 1'b0;
            tgt_q  <= '0;
        end else if (flush_i) begin
            pc <= redirect_pc_i;
            // An outstanding read must be drained unless it returns right now
            case (state)
                S_WAIT:  state <= mem_valid_i ? S_FETCH : S_DROP;
                S_DROP:  state <= mem_valid_i ? S_FETCH : S_DROP;
                default: state <= S_FETCH;
            endcase
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_req_o && mem_ready_i) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_valid_i) begin
                        inst_q <= mem_data_i;
                        pc_q   <= pc;
                        pred_q <= pred;
                        tgt_q  <= pred_tgt;
                        state  <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    pc    <= pred_q ? tgt_q : pc + 32'd4;
                    state <= S_FETCH;
                end
                S_DROP: begin
                    if (mem_valid_i) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus a randomized run
// against a transaction-level model of fetch, prediction and flush.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic        mem_valid_i;
    logic [31:0] mem_data_i;
    logic        iq_full_i;
    logic        iq_we_o;
    logic [31:0] iq_inst_o;
    logic [31:0] iq_pc_o;
    logic        iq_pred_o;
    logic [31:0] iq_pred_target_o;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] JALM8 = 32'hFF9F_F06F;
    localparam logic [31:0] BEQ16 = 32'h0000_0863;

    always #5 clk = ~clk;

    inst_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .redirect_pc_i    (redirect_pc_i),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_ready_i      (mem_ready_i),
        .mem_valid_i      (mem_valid_i),
        .mem_data_i       (mem_data_i),
        .iq_full_i        (iq_full_i),
        .iq_we_o          (iq_we_o),
        .iq_inst_o        (iq_inst_o),
        .iq_pc_o          (iq_pc_o),
        .iq_pred_o        (iq_pred_o),
        .iq_pred_target_o (iq_pred_target_o)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference prediction from the RV32 immediate definitions
    function automatic void predict(input logic [31:0] inst, input logic [31:0] pc,
                                    output logic pred, output logic [31:0] tgt);
        int jimm;
        int bimm;
        jimm = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048
             + int'(inst[19:12]) * 4096 - (inst[31] ? 1048576 : 0);
        bimm = int'(inst[11:8]) * 2 + int'(inst[30:25]) * 32
             + int'(inst[7]) * 2048 - (inst[31] ? 4096 : 0);
        pred = 1'b0;
        tgt  = pc + 32'd4;
        if (inst[6:0] == 7'h6F) begin
            pred = 1'b1;
            tgt  = pc + 32'(jimm);
        end else if (inst[6:0] == 7'h63 && inst[31]) begin
            pred = 1'b1;
            tgt  = pc + 32'(bimm);
        end
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: w[6:0] = 7'h6F;
            1: w[6:0] = 7'h63;
            2: w[6:0] = 7'h67;
            default: ;
        endcase
        return w;
    endfunction

    // Drives one 0-wait fetch starting in an idle cycle; returns observations
    task automatic fetch_one(input logic [31:0] data,
                             output logic req, output logic [31:0] addr,
                             output logic we, output logic [31:0] inst,
                             output logic [31:0] pc, output logic pred,
                             output logic [31:0] tgt);
        flush_i     = 1'b0;
        iq_full_i   = 1'b0;
        mem_ready_i = 1'b1;
        mem_valid_i = 1'b0;
        #1;
        req  = mem_req_o;
        addr = mem_addr_o;
        tick();
        mem_ready_i = 1'b0;
        mem_valid_i = 1'b1;
        mem_data_i  = data;
        tick();
        mem_valid_i = 1'b0;
        #1;
        we   = iq_we_o;
        inst = iq_inst_o;
        pc   = iq_pc_o;
        pred = iq_pred_o;
        tgt  = iq_pred_target_o;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        flush_i = 1'b1;
        redirect_pc_i = 32'h0000_0BAD;
        mem_ready_i = 1'b1;
        mem_valid_i = 1'b1;
        mem_data_i = JALM8;
        iq_full_i = 1'b0;
        tick();
        tick();
        flush_i = 1'b0;
        mem_valid_i = 1'b0;
        #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", mem_req_o); end
        checks++; if (iq_we_o !== 1'b0) begin errors++; $display("FAIL rst_we got %0b exp 0", iq_we_o); end
        checks++; if (mem_addr_o !== 32'h100) begin errors++; $display("FAIL rst_addr got %h exp 00000100", mem_addr_o); end
        checks++; if (iq_inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp 0", iq_inst_o); end
        checks++; if (iq_pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", iq_pc_o); end
        checks++; if (iq_pred_o !== 1'b0) begin errors++; $display("FAIL rst_pred got %0b exp 0", iq_pred_o); end
        checks++; if (iq_pred_target_o !== 32'h0) begin errors++; $display("FAIL rst_tgt got %h exp 0", iq_pred_target_o); end
        rst = 1'b1;
    endtask

    task automatic test_nop_stream();
        logic r, w, p;
        logic [31:0] a, in, pc, t, e;
        for (int i = 0; i < 3; i++) begin
            e = 32'h100 + 32'(4 * i);
            fetch_one(NOP, r, a, w, in, pc, p, t);
            checks++; if (r !== 1'b1) begin errors++; $display("FAIL nop_req[%0d] got %0b exp 1", i, r); end
            checks++; if (a !== e) begin errors++; $display("FAIL nop_addr[%0d] got %h exp %h", i, a, e); end
            checks++; if (w !== 1'b1) begin errors++; $display("FAIL nop_we[%0d] got %0b exp 1", i, w); end
            checks++; if (in !== NOP) begin errors++; $display("FAIL nop_inst[%0d] got %h exp %h", i, in, NOP); end
            checks++; if (pc !== e) begin errors++; $display("FAIL nop_pc[%0d] got %h exp %h", i, pc, e); end
            checks++; if (p !== 1'b0) begin errors++; $display("FAIL nop_pred[%0d] got %0b exp 0", i, p); end
            checks++; if (t !== e + 32'd4) begin errors++; $display("FAIL nop_tgt[%0d] got %h exp %h", i, t, e + 32'd4); end
        end
    endtask

    task automatic test_jal_beq();
        logic r, w, p;
        logic [31:0] a, in, pc, t;
        flush_i = 1'b1;
        redirect_pc_i = 32'h200;
        mem_ready_i = 1'b1;
        #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL flush_fetch_req got %0b exp 0", mem_req_o); end
        tick();
        fetch_one(JALM8, r, a, w, in, pc, p, t);
        checks++; if (a !== 32'h200) begin errors++; $display("FAIL jal_addr got %h exp 00000200", a); end
        checks++; if (w !== 1'b1) begin errors++; $display("FAIL jal_we got %0b exp 1", w); end
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL jal_pc got %h exp 00000200", pc); end
        checks++; if (p !== 1'b1) begin errors++; $display("FAIL jal_pred got %0b exp 1", p); end
        checks++; if (t !== 32'h1F8) begin errors++; $display("FAIL jal_tgt got %h exp 000001f8", t); end
        #1;
        checks++; if (mem_addr_o !== 32'h1F8) begin errors++; $display("FAIL jal_next_addr got %h exp 000001f8", mem_addr_o); end
        flush_i = 1'b1;
        redirect_pc_i = 32'h300;
        tick();
        fetch_one(BEQ16, r, a, w, in, pc, p, t);
        checks++; if (pc !== 32'h300) begin errors++; $display("FAIL beq_pc got %h exp 00000300", pc); end
        checks++; if (p !== 1'b0) begin errors++; $display("FAIL beq_pred got %0b exp 0", p); end
        checks++; if (t !== 32'h304) begin errors++; $display("FAIL beq_tgt got %h exp 00000304", t); end
    endtask

    task automatic test_full_stall();
        logic r, w, p;
        logic [31:0] a, in, pc, t;
        iq_full_i = 1'b1;
        mem_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL full_req[%0d] got %0b exp 0", i, mem_req_o); end
            tick();
        end
        fetch_one(NOP, r, a, w, in, pc, p, t);
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL full_release_req got %0b exp 1", r); end
        checks++; if (a !== 32'h304) begin errors++; $display("FAIL full_release_addr got %h exp 00000304", a); end
        checks++; if (pc !== 32'h304) begin errors++; $display("FAIL full_release_pc got %h exp 00000304", pc); end
    endtask

    task automatic test_flush_wait();
        mem_ready_i = 1'b1;
        #1;
        tick();
        mem_ready_i = 1'b0;
        flush_i = 1'b1;
        redirect_pc_i = 32'h400;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL drop_req[%0d] got %0b exp 0", i, mem_req_o); end
            checks++; if (iq_we_o !== 1'b0) begin errors++; $display("FAIL drop_we[%0d] got %0b exp 0", i, iq_we_o); end
            tick();
        end
        mem_valid_i = 1'b1;
        mem_data_i = JALM8;
        #1;
        checks++; if (iq_we_o !== 1'b0) begin errors++; $display("FAIL stale_we got %0b exp 0", iq_we_o); end
        tick();
        mem_valid_i = 1'b0;
        #1;
        checks++; if (iq_we_o !== 1'b0) begin errors++; $display("FAIL stale_we_after got %0b exp 0", iq_we_o); end
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL redirect_req got %0b exp 1", mem_req_o); end
        checks++; if (mem_addr_o !== 32'h400) begin errors++; $display("FAIL redirect_addr got %h exp 00000400", mem_addr_o); end
    endtask

    task automatic test_ready_stall_flush();
        logic r, w, p;
        logic [31:0] a, in, pc, t, e;
        mem_ready_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            flush_i = (c == 1);
            redirect_pc_i = 32'h500;
            e = (c == 0) ? 32'h400 : 32'h500;
            #1;
            checks++; if (iq_we_o !== 1'b0) begin errors++; $display("FAIL stall_we[%0d] got %0b exp 0", c, iq_we_o); end
            checks++; if (mem_req_o !== (c != 1)) begin errors++; $display("FAIL stall_req[%0d] got %0b exp %0b", c, mem_req_o, c != 1); end
            if (c != 1) begin
                checks++; if (mem_addr_o !== e) begin errors++; $display("FAIL stall_addr[%0d] got %h exp %h", c, mem_addr_o, e); end
            end
            tick();
        end
        fetch_one(NOP, r, a, w, in, pc, p, t);
        checks++; if (a !== 32'h500) begin errors++; $display("FAIL stall_fetch_addr got %h exp 00000500", a); end
        checks++; if (pc !== 32'h500) begin errors++; $display("FAIL stall_push_pc got %h exp 00000500", pc); end
    endtask

    task automatic test_reset_in_push();
        mem_ready_i = 1'b1;
        #1;
        tick();
        mem_ready_i = 1'b0;
        mem_valid_i = 1'b1;
        mem_data_i = JALM8;
        tick();
        mem_valid_i = 1'b0;
        rst = 1'b0;
        tick();
        #1;
        checks++; if (iq_we_o !== 1'b0) begin errors++; $display("FAIL rpush_we got %0b exp 0", iq_we_o); end
        checks++; if (iq_inst_o !== 32'h0) begin errors++; $display("FAIL rpush_inst got %h exp 0", iq_inst_o); end
        checks++; if (iq_pred_o !== 1'b0) begin errors++; $display("FAIL rpush_pred got %0b exp 0", iq_pred_o); end
        checks++; if (mem_addr_o !== 32'h100) begin errors++; $display("FAIL rpush_addr got %h exp 00000100", mem_addr_o); end
        rst = 1'b1;
        #1;
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL rpush_fetch_req got %0b exp 1", mem_req_o); end
        checks++; if (iq_we_o !== 1'b0) begin errors++; $display("FAIL rpush_we_after got %0b exp 0", iq_we_o); end
    endtask

    task automatic test_random();
        bit          outstanding = 0;
        bit          stale = 0;
        bit          push_due = 0;
        int          cnt = 0;
        logic [31:0] exp_pc = 32'h100;
        logic [31:0] req_addr = 32'h0;
        logic [31:0] p_inst = 32'h0;
        logic [31:0] p_pc = 32'h0;
        logic        p_pred = 1'b0;
        logic [31:0] p_tgt = 32'h0;
        bit          exp_req;
        bit          exp_we;
        bit          idle;
        logic        np;
        logic [31:0] nt;
        tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            mem_ready_i = ($urandom_range(0, 9) < 7);
            iq_full_i = ($urandom_range(0, 9) < 2);
            flush_i = ($urandom_range(0, 19) == 0);
            redirect_pc_i = $urandom & 32'hFFFF_FFFC;
            mem_valid_i = 1'b0;
            mem_data_i = $urandom;
            if (outstanding && cnt == 0) begin
                mem_valid_i = 1'b1;
                mem_data_i = gen_inst();
            end else if (!outstanding && $urandom_range(0, 19) == 0) begin
                mem_valid_i = 1'b1;
            end
            #1;
            idle = !outstanding && !push_due;
            exp_req = idle && !iq_full_i && !flush_i;
            exp_we = push_due && !flush_i;
            checks++; if (mem_req_o !== exp_req) begin errors++; $display("FAIL rnd_req[%0d] got %0b exp %0b", cyc, mem_req_o, exp_req); end
            if (idle) begin
                checks++; if (mem_addr_o !== exp_pc) begin errors++; $display("FAIL rnd_addr[%0d] got %h exp %h", cyc, mem_addr_o, exp_pc); end
            end
            checks++; if (iq_we_o !== exp_we) begin errors++; $display("FAIL rnd_we[%0d] got %0b exp %0b", cyc, iq_we_o, exp_we); end
            if (push_due) begin
                checks++;
                if (iq_inst_o !== p_inst || iq_pc_o !== p_pc || iq_pred_o !== p_pred || iq_pred_target_o !== p_tgt) begin
                    errors++;
                    $display("FAIL rnd_push[%0d] got %h/%h/%0b/%h exp %h/%h/%0b/%h", cyc,
                             iq_inst_o, iq_pc_o, iq_pred_o, iq_pred_target_o, p_inst, p_pc, p_pred, p_tgt);
                end
            end
            if (push_due) begin
                if (!flush_i) exp_pc = p_tgt;
                push_due = 0;
            end
            if (outstanding && mem_valid_i) begin
                outstanding = 0;
                if (!stale && !flush_i) begin
                    predict(mem_data_i, req_addr, np, nt);
                    push_due = 1;
                    p_inst = mem_data_i;
                    p_pc = req_addr;
                    p_pred = np;
                    p_tgt = nt;
                end
            end else if (outstanding) begin
                cnt--;
            end
            if (exp_req && mem_ready_i) begin
                outstanding = 1;
                stale = 0;
                cnt = $urandom_range(0, 3);
                req_addr = exp_pc;
            end
            if (flush_i) begin
                exp_pc = redirect_pc_i;
                if (outstanding) stale = 1;
            end
            tick();
        end
        flush_i = 1'b0;
        mem_valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        flush_i = 1'b0;
        redirect_pc_i = 32'h0;
        mem_ready_i = 1'b0;
        mem_valid_i = 1'b0;
        mem_data_i = 32'h0;
        iq_full_i = 1'b0;
        test_reset();
        test_nop_stream();
        test_jal_beq();
        test_full_stall();
        test_flush_wait();
        test_ready_stall_flush();
        test_reset_in_push();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
